decimal_key_entry_ctrl: RTL and testbench
=========================================

# decimal_key_entry_ctrl

Controller that turns a raw one-hot decimal key bus (ten keys, 0–9) into debounced BCD digits. It arbitrates illegal multi-key presses and accumulates up to NDIG digits into a BCD number. Each committed number is handed downstream over a valid/ready handshake. It sits between the keypad input stage and the numeric consumer, and sequences the one-hot-to-BCD encode step.

## Interface
- NDIG, 4, number of BCD digits buffered (≥1)
- DEB_CYCLES, 4, consecutive identical samples required to accept a key (≥2)

- clk  input  1  single clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- key  input  10  one-hot key bus, bit i = decimal digit i; already synchronized to clk
- enter  input  1  commit buffered number (level sampled each cycle)
- clr  input  1  discard buffered number
- out_ready  input  1  downstream ready
- out_valid  output  1  committed number available
- out_bcd  output  4*NDIG  committed number; last-entered digit in [3:0]
- out_count  output  $clog2(NDIG+1)  digits in committed number
- digit_valid  output  1  one-cycle pulse per accepted digit
- digit  output  4  BCD of accepted digit; valid with digit_valid
- err  output  1  one-cycle pulse: multi-hot key or buffer overflow

## Operation
- States:
  - IDLE: no key in progress.
  - DEBOUNCE: key candidate `cand` latched, sample counter `cnt` running.
  - HOLD: waiting for key == 0.
  - OUTPUT: committed number offered downstream.
- Priority in every cycle: rst > clr > enter > key.
- IDLE:
  - key == 0: stay.
  - key one-hot: cand = key, cnt = 1, go to DEBOUNCE.
  - key multi-hot (≥2 bits): err pulse, go to HOLD.
- DEBOUNCE:
  - key == cand: cnt++.
  - When a sample makes cnt == DEB_CYCLES, the digit is accepted. digit = BCD index of cand, digit_valid pulses, go to HOLD.
  - key != cand (including 0 or multi-hot): back to IDLE, no err, nothing accepted.
- Accept, when buffer count < NDIG:
  - buf = {buf[4*(NDIG-1)-1:0], digit}; count++.
- Accept, when count == NDIG:
  - digit_valid still pulses and err pulses.
  - buf and count unchanged.
- HOLD: key == 0 → IDLE; otherwise stay. There is no auto-repeat.
- enter, in IDLE/DEBOUNCE/HOLD:
  - count > 0: out_bcd = buf, out_count = count, out_valid = 1; buf and count cleared; any debounce in progress is aborted; go to OUTPUT.
  - count == 0: enter is ignored.
- OUTPUT:
  - key and enter are ignored.
  - out_valid, out_bcd and out_count are held stable until out_valid && out_ready.
  - On that transfer cycle: out_valid = 0 next cycle, go to HOLD.
- clr, in any state:
  - buf, count, cand and cnt are cleared.
  - out_valid = 0, which abandons a pending transfer; out_bcd and out_count are zeroed.
  - go to HOLD.
  - Suppresses any accept or enter in the same cycle.
- Width rules:
  - Unused upper digits of out_bcd are zero.
  - BCD mapping: key bit i → 4'di, for i = 0..9.

## Timing
- Reset values: state IDLE; out_valid 0, out_bcd 0, out_count 0, digit_valid 0, digit 0, err 0; buf, count, cand, cnt all 0.
- All outputs are registered; no combinational path from any input to any output.
- Debounce latency:
  - If key first becomes one-hot in cycle T (sampled in IDLE) and stays stable through cycle T+DEB_CYCLES-1, then digit_valid = 1 in cycle T+DEB_CYCLES for exactly one cycle.
- err timing: err = 1 in the cycle after the offending sample, for exactly one cycle.
- enter latency: enter sampled high in cycle T → out_valid = 1 from cycle T+1.
- Handshake:
  - A transfer occurs on the edge where out_valid && out_ready.
  - out_valid = 0 in the following cycle.
  - out_ready may be high before out_valid; this costs no extra cycle.
- Reset mid-operation (any state, including OUTPUT):
  - Returns to IDLE next cycle and drops out_valid without a transfer.
  - A key held through reset is debounced afresh.

## Test plan
- Sustained press, DEB_CYCLES=4: key = 10'h080 held 10 cycles → one digit_valid pulse, 4 cycles after the first sample, with digit = 7; no repeat. After key = 0, IDLE.
- Bounce: key 10'h008 for 2 cycles, 0 for 1 cycle, then 10'h008 for 4 cycles → exactly one digit = 3 and no err.
- Multi-hot press: key = 10'b0000100100 → err pulses once, no digit_valid. FSM stays in HOLD until key = 0.
- Enter with stall: enter digits 1, 2, 3, then assert enter with out_ready = 0 for 5 cycles.
  - out_valid is held with out_bcd = 16'h0123 and out_count = 3.
  - Raise out_ready → out_valid = 0 next cycle.
  - A further enter with count 0 is ignored.
- Overflow, NDIG=4: enter digits 9, 8, 7, 6, 5 → the fifth digit gives digit_valid and err together. Then enter → out_bcd = 16'h9876, out_count = 4.
- Abort paths:
  - clr during OUTPUT → out_valid = 0 next cycle, no transfer.
  - rst during DEBOUNCE → nothing accepted.
  - A key held across rst is accepted DEB_CYCLES cycles after rst deasserts.

Source files
------------

// File: rtl/decimal_key_entry_ctrl.sv
// decimal_key_entry_ctrl
//   Debounces a one-hot decimal key bus, packs accepted digits into a BCD
//   number of up to NDIG digits, and offers the committed number downstream
//   over a valid/ready handshake.
//
// Ports
//   clk, rst     clock; synchronous active-high reset
//   key[9:0]     one-hot key bus (bit i = digit i), already synchronous
//   enter        commit the buffered number (ignored when the buffer is empty)
//   clr          discard the buffered number and any pending output
//   out_ready    downstream ready
//   out_valid    committed number available; held until out_ready
//   out_bcd      committed number, last-entered digit in [3:0]
//   out_count    number of digits in out_bcd
//   digit_valid  one-cycle pulse per accepted digit, with digit = its BCD
//   err          one-cycle pulse on a multi-hot key or buffer overflow
module decimal_key_entry_ctrl #(
  parameter int NDIG       = 4,
  parameter int DEB_CYCLES = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [9:0]                  key,
  input  logic                        enter,
  input  logic                        clr,
  input  logic                        out_ready,
  output logic                        out_valid,
  output logic [4*NDIG-1:0]           out_bcd,
  output logic [$clog2(NDIG+1)-1:0]   out_count,
  output logic                        digit_valid,
  output logic [3:0]                  digit,
  output logic                        err
);

  localparam int CW   = $clog2(NDIG+1);
  localparam int CNTW = $clog2(DEB_CYCLES+1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DEBOUNCE = 2'd1,
    S_HOLD     = 2'd2,
    S_OUTPUT   = 2'd3
  } state_t;

  state_t            state;
  logic [4*NDIG-1:0] dbuf;
  logic [CW-1:0]     count;
  logic [9:0]        cand;
  logic [CNTW-1:0]   cnt;

  logic              key_zero, key_onehot, buf_full;
  logic [3:0]        cand_bcd;
  logic [4*NDIG-1:0] dbuf_shift;

  // Index of the highest set bit; only meaningful for a one-hot candidate.
  function automatic logic [3:0] enc(input logic [9:0] k);
    logic [3:0] e;
    e = 4'd0;
    for (int i = 0; i < 10; i++)
      if (k[i]) e = 4'(i);
    return e;
  endfunction

  always_comb begin
    key_zero   = (key == 10'd0);
    // Clearing the lowest set bit leaves zero only for a single-bit value.
    key_onehot = !key_zero && ((key & (key - 10'd1)) == 10'd0);
    buf_full   = (count == CW'(NDIG));
    cand_bcd   = enc(cand);
    // Shift in the new digit at the bottom; the oldest digit falls off the
    // top (never happens in practice since a full buffer is not written).
    dbuf_shift       = dbuf << 4;
    dbuf_shift[3:0]  = cand_bcd;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      dbuf        <= '0;
      count       <= '0;
      cand        <= '0;
      cnt         <= '0;
      out_valid   <= 1'b0;
      out_bcd     <= '0;
      out_count   <= '0;
      digit_valid <= 1'b0;
      digit       <= 4'd0;
      err         <= 1'b0;
    end else begin
      digit_valid <= 1'b0;
      err         <= 1'b0;
      if (clr) begin
        // Drops a pending transfer too; wait for release before new keys.
        dbuf      <= '0;
        count     <= '0;
        cand      <= '0;
        cnt       <= '0;
        out_valid <= 1'b0;
        out_bcd   <= '0;
        out_count <= '0;
        state     <= S_HOLD;
      end else if (state != S_OUTPUT && enter && count != '0) begin
        // Commit wins over key processing, aborting any debounce.
        out_bcd   <= dbuf;
        out_count <= count;
        out_valid <= 1'b1;
        dbuf      <= '0;
        count     <= '0;
        cand      <= '0;
        cnt       <= '0;
        state     <= S_OUTPUT;
      end else begin
        case (state)
          S_IDLE: begin
            if (key_onehot) begin
              cand  <= key;
              cnt   <= CNTW'(1);
              state <= S_DEBOUNCE;
            end else if (!key_zero) begin
              err   <= 1'b1;
              state <= S_HOLD;
            end
          end
          S_DEBOUNCE: begin
            if (key == cand) begin
              if (cnt == CNTW'(DEB_CYCLES-1)) begin
                digit_valid <= 1'b1;
                digit       <= cand_bcd;
                if (buf_full) begin
                  err <= 1'b1;
                end else begin
                  dbuf  <= dbuf_shift;
                  count <= count + CW'(1);
                end
                cand  <= '0;
                cnt   <= '0;
                state <= S_HOLD;
              end else begin
                cnt <= cnt + CNTW'(1);
              end
            end else begin
              // Bounce or release: restart silently.
              cand  <= '0;
              cnt   <= '0;
              state <= S_IDLE;
            end
          end
          S_HOLD: begin
            if (key_zero) state <= S_IDLE;
          end
          S_OUTPUT: begin
            if (out_ready) begin
              out_valid <= 1'b0;
              state     <= S_HOLD;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_decimal_key_entry_ctrl.sv
// Testbench for decimal_key_entry_ctrl: directed table, hand-written corner
// sequences and a randomized run, all checked against a behavioural model
// that tracks the digit buffer as a queue.
module tb_decimal_key_entry_ctrl;

  localparam int NDIG = 4;
  localparam int DEB  = 4;

  logic        clk = 1'b0;
  logic        rst, clr, enter, out_ready;
  logic [9:0]  key;
  logic        out_valid, digit_valid, err;
  logic [15:0] out_bcd;
  logic [2:0]  out_count;
  logic [3:0]  digit;

  int checks = 0;
  int errors = 0;

  decimal_key_entry_ctrl #(.NDIG(NDIG), .DEB_CYCLES(DEB)) dut (
    .clk(clk), .rst(rst), .key(key), .enter(enter), .clr(clr),
    .out_ready(out_ready), .out_valid(out_valid), .out_bcd(out_bcd),
    .out_count(out_count), .digit_valid(digit_valid), .digit(digit),
    .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference ----------------
  int          q[$];       // digits in the entry buffer, oldest first
  bit          m_pend;     // committed number waiting for downstream
  logic [15:0] m_bcd;
  logic [2:0]  m_cnt;
  bit          m_rel;      // must see all keys released before a new press
  int          m_run;      // consecutive samples of the candidate, 0 = none
  logic [9:0]  m_cand;
  bit          m_dv, m_err;
  logic [3:0]  m_dig;

  task automatic model(input logic r, c, e, rdy, input logic [9:0] k);
    m_dv = 0; m_err = 0;
    if (r) begin
      q.delete(); m_pend = 0; m_bcd = 0; m_cnt = 0; m_rel = 0; m_run = 0;
      m_dig = 0;
    end else if (c) begin
      q.delete(); m_pend = 0; m_bcd = 0; m_cnt = 0; m_rel = 1; m_run = 0;
    end else if (!m_pend && e && q.size() > 0) begin
      m_bcd = 0;
      foreach (q[i]) m_bcd = (m_bcd << 4) | 16'(q[i]);
      m_cnt = 3'(q.size());
      q.delete(); m_pend = 1; m_run = 0;
    end else if (m_pend) begin
      if (rdy) begin m_pend = 0; m_rel = 1; end
    end else if (m_rel) begin
      if (k == 0) m_rel = 0;
    end else if (m_run == 0) begin
      if ($countones(k) == 1) begin m_cand = k; m_run = 1; end
      else if (k != 0) begin m_err = 1; m_rel = 1; end
    end else if (k == m_cand) begin
      m_run++;
      if (m_run == DEB) begin
        m_dv = 1; m_dig = 4'($clog2(m_cand));
        if (q.size() < NDIG) q.push_back(int'(m_dig));
        else m_err = 1;
        m_run = 0; m_rel = 1;
      end
    end else begin
      m_run = 0;
    end
  endtask

  task automatic step(input logic r, c, e, rdy, input logic [9:0] k);
    rst = r; clr = c; enter = e; out_ready = rdy; key = k;
    @(posedge clk);
    model(r, c, e, rdy, k);
    #1;
    chk("m_out_valid", out_valid, m_pend);
    chk("m_out_bcd", out_bcd, m_bcd);
    chk("m_out_count", out_count, m_cnt);
    chk("m_digit_valid", digit_valid, m_dv);
    chk("m_err", err, m_err);
    if (m_dv) chk("m_digit", digit, m_dig);
  endtask

  task automatic press(input int d);
    for (int i = 0; i < DEB; i++) step(0, 0, 0, 0, 10'(1 << d));
    step(0, 0, 0, 0, 10'd0);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic       rst, clr, ent, rdy;
    logic [9:0] key;
    logic       dv;
    logic [3:0] dig;
    logic       er;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t row(input logic [9:0] k, input logic dv, input logic [3:0] dg, input logic er);
    vec_t v;
    v.rst = 0; v.clr = 0; v.ent = 0; v.rdy = 0;
    v.key = k; v.dv = dv; v.dig = dg; v.er = er;
    return v;
  endfunction

  logic [9:0] rk;
  int         sel;

  initial begin
    rst = 1; clr = 0; enter = 0; out_ready = 0; key = 0;
    m_pend = 0; m_bcd = 0; m_cnt = 0; m_rel = 0; m_run = 0; m_cand = 0;
    m_dv = 0; m_err = 0; m_dig = 0;

    // Reset state
    step(1, 0, 0, 0, 10'd0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_bcd", out_bcd, 0);
    chk("rst_out_count", out_count, 0);
    chk("rst_digit_valid", digit_valid, 0);
    chk("rst_digit", digit, 0);
    chk("rst_err", err, 0);

    // Sustained press of 7: single pulse after 4 samples, no repeat
    for (int i = 0; i < 10; i++) tv.push_back(row(10'h080, i == 3, 4'd7, 0));
    tv.push_back(row(10'h000, 0, 0, 0));
    // Bounce on 3
    tv.push_back(row(10'h008, 0, 0, 0));
    tv.push_back(row(10'h008, 0, 0, 0));
    tv.push_back(row(10'h000, 0, 0, 0));
    for (int i = 0; i < 4; i++) tv.push_back(row(10'h008, i == 3, 4'd3, 0));
    tv.push_back(row(10'h000, 0, 0, 0));
    // Multi-hot: one err, then stuck in HOLD even when a clean key follows
    for (int i = 0; i < 4; i++) tv.push_back(row(10'b0000100100, 0, 0, i == 0));
    for (int i = 0; i < 5; i++) tv.push_back(row(10'h002, 0, 0, 0));
    tv.push_back(row(10'h000, 0, 0, 0));
    // Back in IDLE: digit 0 accepted on time
    for (int i = 0; i < 4; i++) tv.push_back(row(10'h001, i == 3, 4'd0, 0));
    tv.push_back(row(10'h000, 0, 0, 0));

    foreach (tv[i]) begin
      step(tv[i].rst, tv[i].clr, tv[i].ent, tv[i].rdy, tv[i].key);
      chk($sformatf("tv%0d_dv", i), digit_valid, tv[i].dv);
      chk($sformatf("tv%0d_err", i), err, tv[i].er);
      if (tv[i].dv) chk($sformatf("tv%0d_digit", i), digit, tv[i].dig);
    end

    // Enter with stall
    step(0, 1, 0, 0, 10'd0);
    step(0, 0, 0, 0, 10'd0);
    press(1); press(2); press(3);
    step(0, 0, 1, 0, 10'd0);
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", out_valid, 1);
      chk("stall_bcd", out_bcd, 16'h0123);
      chk("stall_count", out_count, 3);
      step(0, 0, 1, 0, 10'h010);
    end
    chk("stall_valid_end", out_valid, 1);
    step(0, 0, 0, 1, 10'd0);
    chk("xfer_valid_drop", out_valid, 0);
    step(0, 0, 0, 0, 10'd0);
    step(0, 0, 1, 0, 10'd0);
    chk("enter_empty_ignored", out_valid, 0);

    // Overflow
    press(9); press(8); press(7); press(6);
    for (int i = 0; i < DEB; i++) step(0, 0, 0, 0, 10'h020);
    chk("ovf_dv", digit_valid, 1);
    chk("ovf_err", err, 1);
    chk("ovf_digit", digit, 5);
    step(0, 0, 0, 0, 10'd0);
    step(0, 0, 1, 1, 10'd0);
    chk("ovf_bcd", out_bcd, 16'h9876);
    chk("ovf_count", out_count, 4);
    chk("ovf_valid", out_valid, 1);
    step(0, 0, 0, 1, 10'd0);
    chk("ovf_drain", out_valid, 0);
    step(0, 0, 0, 0, 10'd0);

    // clr during OUTPUT
    press(4);
    step(0, 0, 1, 0, 10'd0);
    chk("clr_pre_valid", out_valid, 1);
    step(0, 1, 0, 0, 10'd0);
    chk("clr_valid", out_valid, 0);
    chk("clr_bcd", out_bcd, 0);
    chk("clr_count", out_count, 0);
    step(0, 0, 0, 0, 10'd0);

    // rst during OUTPUT
    press(2);
    step(0, 0, 1, 0, 10'd0);
    step(1, 0, 0, 0, 10'd0);
    chk("rst_out_drop", out_valid, 0);
    chk("rst_out_bcd", out_bcd, 0);

    // rst during DEBOUNCE with the key held through it
    step(0, 0, 0, 0, 10'h004);
    step(0, 0, 0, 0, 10'h004);
    step(1, 0, 0, 0, 10'h004);
    chk("rst_deb_dv", digit_valid, 0);
    for (int i = 0; i < DEB; i++) begin
      step(0, 0, 0, 0, 10'h004);
      chk($sformatf("held_dv%0d", i), digit_valid, i == DEB - 1);
    end
    chk("held_digit", digit, 2);
    step(0, 0, 0, 0, 10'd0);

    // Randomized run against the model
    rk = 0;
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 99) < 20) begin
        sel = $urandom_range(0, 99);
        if (sel < 40) rk = 0;
        else if (sel < 85) rk = 10'(1 << $urandom_range(0, 9));
        else rk = 10'(1 << $urandom_range(0, 4)) | 10'(1 << $urandom_range(5, 9));
      end
      step($urandom_range(0, 199) == 0, $urandom_range(0, 99) < 2,
           $urandom_range(0, 99) < 4, $urandom_range(0, 1) == 1, rk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
